// File: rtl/lpc_acc_if.sv
// lpc_acc_if: operand, multiplier-output and result bus of the LPC accumulator
// Parameters: ACC_W result width, CNT_W term-count width.
// Signals: op_valid/op_last/op_mode operand issue, in_ready issue permission,
//   mac_in multiplier output, out_valid/out_ready result handshake,
//   acc_out/acc_cnt/acc_mode result, err sticky flags, err_clr flag clear.
// Modports: master = controller/consumer side, slave = accumulator.
interface lpc_acc_if #(
   parameter int ACC_W = 32,
   parameter int CNT_W = 16
);
   logic             op_valid;
   logic             op_last;
   logic [1:0]       op_mode;
   logic             in_ready;
   logic [15:0]      mac_in;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] acc_out;
   logic [CNT_W-1:0] acc_cnt;
   logic [1:0]       acc_mode;
   logic [2:0]       err;
   logic             err_clr;
   modport master (output op_valid, op_last, op_mode, mac_in, out_ready, err_clr,
                   input  in_ready, out_valid, acc_out, acc_cnt, acc_mode, err);
   modport slave  (input  op_valid, op_last, op_mode, mac_in, out_ready, err_clr,
                   output in_ready, out_valid, acc_out, acc_cnt, acc_mode, err);
endinterface

// File: rtl/lpc_accumulator.sv
// lpc_accumulator: burst accumulator behind the LPC multiplier with valid/ready result register
// Ports: clk rising-edge clock, rst_n async active-low reset,
//   bus (lpc_acc_if.slave) operand issue, mac_in, result handshake and err flags.
// Macro LPC_ACC_SAT_EN: saturating accumulator adds instead of two's-complement wrap.
module lpc_accumulator #(
   parameter int ACC_W   = 32,
   parameter int MUL_LAT = 2,
   parameter int CNT_W   = 16
) (
   input  logic     clk,
   input  logic     rst_n,
   lpc_acc_if.slave bus
);
   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_ACC  = 1'b1;
`ifdef LPC_ACC_SAT_EN
   localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif
   logic [0:0]           r_state;
   logic [MUL_LAT-1:0]   r_v, r_l;
   logic [2*MUL_LAT-1:0] r_m;
   logic                 r_up, r_ov;
   logic [ACC_W-1:0]     r_acc, r_out;
   logic [CNT_W-1:0]     r_cnt, r_ocnt;
   logic [1:0]           r_bmode, r_omode;
   logic [2:0]           r_err;
   logic                 w_tv, w_tl, w_idle, w_ovf, w_can;
   logic [1:0]           w_tm, w_mode;
   logic [ACC_W-1:0]     w_term, w_base, w_sum, w_res;
   logic [CNT_W-1:0]     w_cnt;
   logic [2:0]           w_ev;
   // Oldest delay stage is term T, aligned with mac_in.
   always_comb begin
      w_tv   = r_v[MUL_LAT-1];
      w_tl   = w_tv & r_l[MUL_LAT-1];
      w_tm   = r_m[2*MUL_LAT-1 -: 2];
      w_idle = r_state == S_IDLE;
      w_term = (w_tm == 2'b11) ? '0 : {{(ACC_W-16){bus.mac_in[15]}}, bus.mac_in};
      w_base = w_idle ? '0 : r_acc;
      w_sum  = w_base + w_term;
      w_ovf  = (w_base[ACC_W-1] == w_term[ACC_W-1]) && (w_sum[ACC_W-1] != w_base[ACC_W-1]);
`ifdef LPC_ACC_SAT_EN
      w_res  = w_ovf ? (w_base[ACC_W-1] ? ACC_MIN : ACC_MAX) : w_sum;
`else
      w_res  = w_sum;
`endif
      w_cnt  = w_idle ? CNT_W'(1) : (&r_cnt ? r_cnt : r_cnt + 1'b1);
      w_mode = w_idle ? w_tm : r_bmode;
      w_can  = !r_ov || bus.out_ready;
      w_ev   = {w_tv & w_ovf, w_tv & !w_idle & (w_tm != r_bmode), w_tl & !w_can};
   end
   assign bus.in_ready  = r_up & !r_ov & ~|r_l;
   assign bus.out_valid = r_ov;
   assign bus.acc_out   = r_out;
   assign bus.acc_cnt   = r_ocnt;
   assign bus.acc_mode  = r_omode;
   assign bus.err       = r_err;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_v     <= '0;
         r_l     <= '0;
         r_m     <= '0;
         r_up    <= 1'b0;
         r_ov    <= 1'b0;
         r_acc   <= '0;
         r_out   <= '0;
         r_cnt   <= '0;
         r_ocnt  <= '0;
         r_bmode <= '0;
         r_omode <= '0;
         r_err   <= '0;
      end else begin
         r_up  <= 1'b1;
         r_v   <= MUL_LAT'({r_v, bus.op_valid});
         r_l   <= MUL_LAT'({r_l, bus.op_valid & bus.op_last});
         r_m   <= (2*MUL_LAT)'({r_m, bus.op_mode});
         r_err <= (bus.err_clr ? 3'b000 : r_err) | w_ev;
         if (w_tv) begin
            r_state <= w_tl ? S_IDLE : S_ACC;
            r_acc   <= w_tl ? '0 : w_res;
            r_cnt   <= w_tl ? '0 : w_cnt;
            if (w_idle) r_bmode <= w_tm;
         end
         // A result that cannot be loaded is dropped; the held one stays.
         if (w_tl && w_can) begin
            r_ov    <= 1'b1;
            r_out   <= w_res;
            r_ocnt  <= w_cnt;
            r_omode <= w_mode;
         end else if (bus.out_ready) r_ov <= 1'b0;
      end
   end
endmodule

// File: tb/tb_lpc_accumulator.sv
// tb_lpc_accumulator: directed and randomized checks of lpc_accumulator against a burst-level model
module tb_lpc_accumulator;
   localparam int LAT = 2;
   typedef struct {
      logic [31:0] sum;
      logic [15:0] cnt;
      logic [1:0]  mode;
   } exp_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int checks = 0;
   int errors = 0;
   exp_t q_exp[$];
   bit m_in = 0;
   bit m_err1 = 0;
   longint m_acc = 0;
   int m_cnt = 0;
   logic [1:0] m_mode = 2'b00;
   bit done = 0;

   lpc_acc_if #(.ACC_W(32), .CNT_W(16)) bus ();
   lpc_acc_if #(.ACC_W(20), .CNT_W(16)) bus2 ();
   lpc_accumulator #(.ACC_W(32), .MUL_LAT(LAT), .CNT_W(16)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   lpc_accumulator #(.ACC_W(20), .MUL_LAT(LAT), .CNT_W(16)) u_ov  (.clk(clk), .rst_n(rst_n), .bus(bus2));

   always #5 clk = ~clk;

   function automatic longint fold(input longint s, input int w, output bit ovf);
      longint hi, lo;
      hi = (longint'(1) <<< (w - 1)) - 1;
      lo = -(longint'(1) <<< (w - 1));
      ovf = (s > hi) || (s < lo);
`ifdef LPC_ACC_SAT_EN
      return (s > hi) ? hi : (s < lo) ? lo : s;
`else
      return (s > hi) ? s - (longint'(1) <<< w) : (s < lo) ? s + (longint'(1) <<< w) : s;
`endif
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset;
      q_exp.delete();
      m_in = 0;
      m_err1 = 0;
   endtask

   // Drives one issue cycle, schedules mac_in LAT cycles later and updates the burst model.
   task automatic issue(input bit v, input bit l, input logic [1:0] m, input logic [15:0] mac);
      longint t, r;
      bit o;
      bus.op_valid = v;
      bus.op_last = l;
      bus.op_mode = m;
      if (v) begin
         fork
            begin
               repeat (LAT) @(posedge clk);
               #1 bus.mac_in = mac;
            end
         join_none
         t = (m == 2'b11) ? 0 : longint'($signed(mac));
         if (!m_in) begin
            m_acc = 0;
            m_cnt = 0;
            m_mode = m;
         end else if (m != m_mode) m_err1 = 1;
         r = fold(m_acc + t, 32, o);
         m_cnt = (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
         if (l) begin
            q_exp.push_back('{32'(r), 16'(m_cnt), m_mode});
            m_in = 0;
         end else begin
            m_acc = r;
            m_in = 1;
         end
      end
      tick;
      bus.op_valid = 1'b0;
      bus.op_last = 1'b0;
   endtask

   task automatic test_reset;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({bus.in_ready, bus.out_valid, bus.acc_out, bus.acc_cnt, bus.acc_mode, bus.err} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got rdy=%b ov=%b acc=%h cnt=%0d mode=%b err=%b want all 0",
                  bus.in_ready, bus.out_valid, bus.acc_out, bus.acc_cnt, bus.acc_mode, bus.err);
      end
      rst_n = 1'b1;
      tick;
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
      end
   endtask

   task automatic test_single;
      bus.out_ready = 1'b0;
      issue(1, 1, 2'b10, 16'hFFF1);
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_early1 out_valid got %b want 0", bus.out_valid);
      end
      tick;
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_early2 out_valid got %b want 0", bus.out_valid);
      end
      tick;
      checks++;
      if ({bus.out_valid, bus.acc_out, bus.acc_cnt, bus.acc_mode, bus.err} !== {1'b1, 32'hFFFFFFF1, 16'd1, 2'b10, 3'b000}) begin
         errors++;
         $display("FAIL single_result got ov=%b acc=%h cnt=%0d mode=%b err=%b want ov=1 acc=fffffff1 cnt=1 mode=10 err=000",
                  bus.out_valid, bus.acc_out, bus.acc_cnt, bus.acc_mode, bus.err);
      end
      bus.out_ready = 1'b1;
      tick;
      bus.out_ready = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_taken out_valid got %b want 0", bus.out_valid);
      end
   endtask

   task automatic test_burst;
      int n = 0;
      issue(1, 0, 2'b01, 16'd100);
      issue(1, 0, 2'b01, 16'd200);
      issue(1, 0, 2'b01, 16'hFFCE);
      issue(1, 1, 2'b01, 16'd7);
      checks++;
      if (bus.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL burst_in_ready_after_last got %b want 0", bus.in_ready);
      end
      while (!bus.out_valid && n < 20) begin
         tick;
         n++;
      end
      checks++;
      if ({bus.out_valid, bus.acc_out, bus.acc_cnt, bus.acc_mode, bus.in_ready} !== {1'b1, 32'd257, 16'd4, 2'b01, 1'b0}) begin
         errors++;
         $display("FAIL burst_result got ov=%b acc=%0d cnt=%0d mode=%b rdy=%b want ov=1 acc=257 cnt=4 mode=01 rdy=0",
                  bus.out_valid, bus.acc_out, bus.acc_cnt, bus.acc_mode, bus.in_ready);
      end
   endtask

   task automatic test_backpressure;
      issue(1, 1, 2'b01, 16'd5);
      repeat (3) tick;
      checks++;
      if ({bus.out_valid, bus.acc_out, bus.acc_cnt, bus.err} !== {1'b1, 32'd257, 16'd4, 3'b001}) begin
         errors++;
         $display("FAIL drop_hold got ov=%b acc=%0d cnt=%0d err=%b want ov=1 acc=257 cnt=4 err=001",
                  bus.out_valid, bus.acc_out, bus.acc_cnt, bus.err);
      end
      bus.out_ready = 1'b1;
      tick;
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL drop_take out_valid got %b want 0", bus.out_valid);
      end
      bus.err_clr = 1'b1;
      tick;
      bus.err_clr = 1'b0;
      bus.out_ready = 1'b0;
      checks++;
      if (bus.err !== 3'b000) begin
         errors++;
         $display("FAIL drop_err_clr got %b want 000", bus.err);
      end
   endtask

   task automatic test_mismatch;
      int n = 0;
      issue(1, 0, 2'b00, 16'd1);
      issue(1, 0, 2'b01, 16'd2);
      issue(1, 1, 2'b00, 16'd3);
      while (!bus.out_valid && n < 20) begin
         tick;
         n++;
      end
      checks++;
      if ({bus.out_valid, bus.acc_out, bus.acc_cnt, bus.acc_mode, bus.err} !== {1'b1, 32'd6, 16'd3, 2'b00, 3'b010}) begin
         errors++;
         $display("FAIL mismatch_result got ov=%b acc=%0d cnt=%0d mode=%b err=%b want ov=1 acc=6 cnt=3 mode=00 err=010",
                  bus.out_valid, bus.acc_out, bus.acc_cnt, bus.acc_mode, bus.err);
      end
      bus.out_ready = 1'b1;
      bus.err_clr = 1'b1;
      tick;
      bus.err_clr = 1'b0;
   endtask

   task automatic test_overflow;
      longint e = 0;
      bit o, any = 0;
      int n = 0;
      bus2.mac_in = 16'h7FFF;
      bus2.op_mode = 2'b10;
      for (int i = 0; i < 20; i++) begin
         bus2.op_valid = 1'b1;
         bus2.op_last = (i == 19);
         e = fold(e + 32767, 20, o);
         any |= o;
         tick;
      end
      bus2.op_valid = 1'b0;
      bus2.op_last = 1'b0;
      while (!bus2.out_valid && n < 20) begin
         tick;
         n++;
      end
      checks++;
      if ({bus2.out_valid, bus2.acc_out, bus2.acc_cnt, bus2.err[2]} !== {1'b1, 20'(e), 16'd20, any}) begin
         errors++;
         $display("FAIL overflow_result got ov=%b acc=%h cnt=%0d err2=%b want ov=1 acc=%h cnt=20 err2=%b",
                  bus2.out_valid, bus2.acc_out, bus2.acc_cnt, bus2.err[2], 20'(e), any);
      end
   endtask

   task automatic test_reset_mid;
      int n = 0;
      bus.out_ready = 1'b1;
      issue(1, 0, 2'b01, 16'd10);
      issue(1, 0, 2'b01, 16'd20);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.in_ready, bus.out_valid, bus.acc_out, bus.acc_cnt, bus.acc_mode, bus.err} !== '0) begin
         errors++;
         $display("FAIL midreset_outputs got rdy=%b ov=%b acc=%h cnt=%0d mode=%b err=%b want all 0",
                  bus.in_ready, bus.out_valid, bus.acc_out, bus.acc_cnt, bus.acc_mode, bus.err);
      end
      #2 rst_n = 1'b1;
      model_reset();
      tick;
      issue(1, 1, 2'b00, 16'd9);
      while (!bus.out_valid && n < 20) begin
         tick;
         n++;
      end
      checks++;
      if ({bus.out_valid, bus.acc_out, bus.acc_cnt} !== {1'b1, 32'd9, 16'd1}) begin
         errors++;
         $display("FAIL midreset_next got ov=%b acc=%0d cnt=%0d want ov=1 acc=9 cnt=1",
                  bus.out_valid, bus.acc_out, bus.acc_cnt);
      end
      tick;
   endtask

   task automatic test_back_to_back;
      exp_t e;
      model_reset();
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) issue(1, 1, 2'($urandom_range(0, 3)), 16'($urandom));
      for (int i = 0; i < 3; i++) begin
         e = q_exp.pop_front();
         checks++;
         if ({bus.out_valid, bus.acc_out, bus.acc_cnt, bus.acc_mode} !== {1'b1, e.sum, e.cnt, e.mode}) begin
            errors++;
            $display("FAIL b2b_%0d got ov=%b acc=%h cnt=%0d mode=%b want ov=1 acc=%h cnt=%0d mode=%b",
                     i, bus.out_valid, bus.acc_out, bus.acc_cnt, bus.acc_mode, e.sum, e.cnt, e.mode);
         end
         tick;
      end
   endtask

   task automatic test_random;
      model_reset();
      bus.out_ready = 1'b1;
      bus.err_clr = 1'b1;
      tick;
      bus.err_clr = 1'b0;
      done = 0;
      fork
         begin
            for (int b = 0; b < 40; b++) begin
               int len;
               logic [1:0] bm;
               len = $urandom_range(1, 5);
               bm = 2'($urandom_range(0, 3));
               for (int k = 0; k < len; k++) begin
                  logic [1:0] tm;
                  tm = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : bm;
                  issue(1, k == len - 1, tm, 16'($urandom));
                  if ($urandom_range(0, 3) == 0) tick;
               end
               repeat ($urandom_range(0, 2)) tick;
            end
            done = 1;
         end
         begin
            int n = 0;
            exp_t e;
            while (!(done && q_exp.size() == 0) && n < 3000) begin
               tick;
               n++;
               if (bus.out_valid) begin
                  checks++;
                  if (q_exp.size() == 0) begin
                     errors++;
                     $display("FAIL rand_unexpected got acc=%h with no result pending", bus.acc_out);
                  end else begin
                     e = q_exp.pop_front();
                     if ({bus.acc_out, bus.acc_cnt, bus.acc_mode} !== {e.sum, e.cnt, e.mode}) begin
                        errors++;
                        $display("FAIL rand_result got acc=%h cnt=%0d mode=%b want acc=%h cnt=%0d mode=%b",
                                 bus.acc_out, bus.acc_cnt, bus.acc_mode, e.sum, e.cnt, e.mode);
                     end
                  end
               end
            end
         end
      join
      checks++;
      if (q_exp.size() != 0) begin
         errors++;
         $display("FAIL rand_missing got %0d results outstanding want 0", q_exp.size());
      end
      checks++;
      if (bus.err !== {1'b0, m_err1, 1'b0}) begin
         errors++;
         $display("FAIL rand_err got %b want %b", bus.err, {1'b0, m_err1, 1'b0});
      end
   endtask

   initial begin
      bus.op_valid = 1'b0;
      bus.op_last = 1'b0;
      bus.op_mode = 2'b00;
      bus.mac_in = 16'h0000;
      bus.out_ready = 1'b0;
      bus.err_clr = 1'b0;
      bus2.op_valid = 1'b0;
      bus2.op_last = 1'b0;
      bus2.op_mode = 2'b00;
      bus2.mac_in = 16'h0000;
      bus2.out_ready = 1'b0;
      bus2.err_clr = 1'b0;
      test_reset();
      test_single();
      test_burst();
      test_backpressure();
      test_mismatch();
      test_overflow();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog got timeout want bench completion");
      $fatal(1, "watchdog");
   end
endmodule
